// File: rtl/pc_mux_reg_pkg.sv
// Shared definitions for the fetch-stage next-PC selector: index-width rule,
// default reset PC and the candidate-source encoding.
package pc_mux_reg_pkg;

   // PC value loaded on reset unless the instance overrides it.
   localparam int unsigned DEFAULT_RESET_PC = 0;

   // Where the next PC comes from on a non-stalled cycle.
   typedef enum logic [1:0] {
      SEL_SEQ  = 2'd0,   // sequential increment
      SEL_LIVE = 2'd1,   // redirect requested this cycle
      SEL_PEND = 2'd2    // redirect captured earlier during a stall
   } sel_e;

   // Ceiling log2; clog2(0) and clog2(1) both return 0.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // Source-index width: clog2 of the source count, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n_src);
      int unsigned w;
      w = clog2(n_src);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pc_prio_enc.sv
// Combinational priority encoder over the redirect request vector; the
// highest set index wins.
module pc_prio_enc #(
   parameter int unsigned N_SRC = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_SRC-1:0] src_valid,
   output logic             any_valid,
   output logic [IDX_W-1:0] win_idx
);

   // Scan upward so the last (highest) valid index overrides lower ones.
   always_comb begin
      any_valid = 1'b0;
      win_idx   = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (src_valid[i]) begin
            any_valid = 1'b1;
            win_idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/pc_mux_reg.sv
// Fetch-stage next-PC selector and PC register. Chooses between the sequential
// increment, a live redirect and a redirect captured during a stall, and flags
// redirected fetches so later stages can squash.
module pc_mux_reg
   import pc_mux_reg_pkg::*;
#(
   parameter  int unsigned ADDR_W   = 10,
   parameter  int unsigned N_SRC    = 4,
   parameter  int unsigned INC      = 1,
   parameter  int unsigned RESET_PC = DEFAULT_RESET_PC,
   localparam int unsigned IDX_W    = idx_width(N_SRC)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stall,
   input  logic [N_SRC-1:0]        src_valid,
   input  logic [N_SRC*ADDR_W-1:0] src_addr,
   output logic [ADDR_W-1:0]       pc,
   output logic                    redirect,
   output logic [IDX_W-1:0]        redirect_idx,
   output logic                    pending
);

   localparam logic [ADDR_W-1:0] RST_PC_V = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] INC_V    = ADDR_W'(INC);

   // Architectural state
   logic [ADDR_W-1:0] pc_q,        pc_d;
   logic              redirect_q,  redirect_d;
   logic [IDX_W-1:0]  redir_idx_q, redir_idx_d;
   logic              pend_q,      pend_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [IDX_W-1:0]  pend_idx_q,  pend_idx_d;

   // Live winner
   logic              live_any;
   logic [IDX_W-1:0]  live_idx;
   logic [ADDR_W-1:0] live_addr;
   logic              live_takes;
   sel_e              sel;

   pc_prio_enc #(
      .N_SRC (N_SRC),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .src_valid (src_valid),
      .any_valid (live_any),
      .win_idx   (live_idx)
   );

   // Extract the winning source's target address from the flattened bus.
   always_comb begin
      live_addr = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (IDX_W'(i) == live_idx) begin
            live_addr = src_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Live request beats the pending entry when its index is at least as high;
   // this same test gates capture during a stall.
   always_comb begin
      live_takes = live_any && (!pend_q || (live_idx >= pend_idx_q));
      if (live_takes) begin
         sel = SEL_LIVE;
      end else if (pend_q) begin
         sel = SEL_PEND;
      end else begin
         sel = SEL_SEQ;
      end
   end

   // Next-state logic for PC, redirect flag and pending capture.
   always_comb begin
      pc_d        = pc_q;
      redirect_d  = 1'b0;
      redir_idx_d = '0;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      pend_idx_d  = pend_idx_q;

      if (stall) begin
         if (live_takes) begin
            pend_d      = 1'b1;
            pend_addr_d = live_addr;
            pend_idx_d  = live_idx;
         end
      end else begin
         pend_d = 1'b0;
         unique case (sel)
            SEL_LIVE: begin
               pc_d        = live_addr;
               redirect_d  = 1'b1;
               redir_idx_d = live_idx;
            end
            SEL_PEND: begin
               pc_d        = pend_addr_q;
               redirect_d  = 1'b1;
               redir_idx_d = pend_idx_q;
            end
            default: begin
               pc_d = pc_q + INC_V;
            end
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RST_PC_V;
         redirect_q  <= 1'b0;
         redir_idx_q <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         pend_idx_q  <= '0;
      end else begin
         pc_q        <= pc_d;
         redirect_q  <= redirect_d;
         redir_idx_q <= redir_idx_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         pend_idx_q  <= pend_idx_d;
      end
   end

   assign pc           = pc_q;
   assign redirect     = redirect_q;
   assign redirect_idx = redir_idx_q;
   assign pending      = pend_q;

endmodule

// File: tb/tb_pc_mux_reg.sv
// Directed bench for pc_mux_reg with default parameters (ADDR_W=10, N_SRC=4).
module tb_pc_mux_reg;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic [3:0]  src_valid = '0;
   logic [39:0] src_addr = '0;
   logic [9:0]  pc;
   logic        redirect;
   logic [1:0]  redirect_idx;
   logic        pending;

   int total = 0;
   int bad   = 0;

   pc_mux_reg #(
      .ADDR_W   (10),
      .N_SRC    (4),
      .INC      (1),
      .RESET_PC (0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .src_valid    (src_valid),
      .src_addr     (src_addr),
      .pc           (pc),
      .redirect     (redirect),
      .redirect_idx (redirect_idx),
      .pending      (pending)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic [9:0] a);
      src_addr[i*10 +: 10] = a;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      total++;
      if ({pc, redirect, redirect_idx, pending} !== {10'h000, 1'b0, 2'd0, 1'b0}) begin
         bad++;
         $display("FAIL reset: pc=%h r=%b i=%0d p=%b want pc=000 r=0 i=0 p=0",
                  pc, redirect, redirect_idx, pending);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_freerun();
      for (int k = 1; k <= 3; k++) begin
         step();
         total++;
         if ({pc, redirect, redirect_idx, pending} !== {10'(k), 1'b0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL freerun[%0d]: pc=%h r=%b i=%0d p=%b want pc=%h r=0 i=0 p=0",
                     k, pc, redirect, redirect_idx, pending, 10'(k));
         end
      end
   endtask

   task automatic test_wrap();
      logic [9:0] exp_pc;
      exp_pc = 10'd3;
      for (int n = 0; n < 1100 && exp_pc != 10'h3FF; n++) begin
         step();
         exp_pc = exp_pc + 10'd1;
         total++;
         if (pc !== exp_pc || redirect !== 1'b0) begin
            bad++;
            $display("FAIL wrap_count: pc=%h r=%b want pc=%h r=0", pc, redirect, exp_pc);
         end
      end
      total++;
      if (exp_pc != 10'h3FF) begin
         bad++;
         $display("FAIL wrap_budget: exp_pc=%h want 3ff", exp_pc);
      end
      step();
      total++;
      if ({pc, redirect, redirect_idx, pending} !== {10'h000, 1'b0, 2'd0, 1'b0}) begin
         bad++;
         $display("FAIL wrap_to_zero: pc=%h r=%b i=%0d p=%b want pc=000 r=0 i=0 p=0",
                  pc, redirect, redirect_idx, pending);
      end
   endtask

   task automatic test_priority();
      set_src(0, 10'h010);
      set_src(2, 10'h2A0);
      src_valid = 4'b0101;
      step();
      total++;
      if ({pc, redirect, redirect_idx, pending} !== {10'h2A0, 1'b1, 2'd2, 1'b0}) begin
         bad++;
         $display("FAIL prio_pick: pc=%h r=%b i=%0d p=%b want pc=2a0 r=1 i=2 p=0",
                  pc, redirect, redirect_idx, pending);
      end
      src_valid = 4'b0000;
      step();
      total++;
      if ({pc, redirect, redirect_idx, pending} !== {10'h2A1, 1'b0, 2'd0, 1'b0}) begin
         bad++;
         $display("FAIL prio_after: pc=%h r=%b i=%0d p=%b want pc=2a1 r=0 i=0 p=0",
                  pc, redirect, redirect_idx, pending);
      end
   endtask

   task automatic test_stall_capture();
      logic [3:0] vec [4];
      vec[0] = 4'b0010;
      vec[1] = 4'b1000;
      vec[2] = 4'b0001;
      vec[3] = 4'b0000;
      set_src(1, 10'h050);
      set_src(3, 10'h300);
      set_src(0, 10'h011);
      stall = 1'b1;
      for (int c = 0; c < 4; c++) begin
         src_valid = vec[c];
         step();
         total++;
         if ({pc, redirect, redirect_idx, pending} !== {10'h2A1, 1'b0, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL stall_hold[%0d]: pc=%h r=%b i=%0d p=%b want pc=2a1 r=0 i=0 p=1",
                     c, pc, redirect, redirect_idx, pending);
         end
      end
      stall = 1'b0;
      src_valid = 4'b0000;
      step();
      total++;
      if ({pc, redirect, redirect_idx, pending} !== {10'h300, 1'b1, 2'd3, 1'b0}) begin
         bad++;
         $display("FAIL stall_release: pc=%h r=%b i=%0d p=%b want pc=300 r=1 i=3 p=0",
                  pc, redirect, redirect_idx, pending);
      end
      step();
      total++;
      if ({pc, redirect, redirect_idx, pending} !== {10'h301, 1'b0, 2'd0, 1'b0}) begin
         bad++;
         $display("FAIL stall_after: pc=%h r=%b i=%0d p=%b want pc=301 r=0 i=0 p=0",
                  pc, redirect, redirect_idx, pending);
      end
   endtask

   task automatic test_live_vs_pending();
      // Higher live index beats pending idx 1.
      set_src(1, 10'h050);
      set_src(2, 10'h123);
      set_src(0, 10'h3F0);
      stall = 1'b1;
      src_valid = 4'b0010;
      step();
      stall = 1'b0;
      src_valid = 4'b0100;
      step();
      total++;
      if ({pc, redirect, redirect_idx, pending} !== {10'h123, 1'b1, 2'd2, 1'b0}) begin
         bad++;
         $display("FAIL live_beats_pend: pc=%h r=%b i=%0d p=%b want pc=123 r=1 i=2 p=0",
                  pc, redirect, redirect_idx, pending);
      end
      src_valid = 4'b0000;
      step();
      total++;
      if ({pc, redirect, pending} !== {10'h124, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL pend_dropped: pc=%h r=%b p=%b want pc=124 r=0 p=0",
                  pc, redirect, pending);
      end
      // Lower live index loses to pending idx 1.
      stall = 1'b1;
      src_valid = 4'b0010;
      step();
      stall = 1'b0;
      src_valid = 4'b0001;
      step();
      total++;
      if ({pc, redirect, redirect_idx, pending} !== {10'h050, 1'b1, 2'd1, 1'b0}) begin
         bad++;
         $display("FAIL pend_beats_live: pc=%h r=%b i=%0d p=%b want pc=050 r=1 i=1 p=0",
                  pc, redirect, redirect_idx, pending);
      end
      // Equal index during stall keeps the newest address.
      stall = 1'b1;
      src_valid = 4'b0010;
      set_src(1, 10'h050);
      step();
      set_src(1, 10'h077);
      step();
      stall = 1'b0;
      src_valid = 4'b0000;
      step();
      total++;
      if ({pc, redirect, redirect_idx, pending} !== {10'h077, 1'b1, 2'd1, 1'b0}) begin
         bad++;
         $display("FAIL equal_overwrite: pc=%h r=%b i=%0d p=%b want pc=077 r=1 i=1 p=0",
                  pc, redirect, redirect_idx, pending);
      end
      // Tie between live and pending at the same index: live address used.
      stall = 1'b1;
      src_valid = 4'b0100;
      set_src(2, 10'h155);
      step();
      stall = 1'b0;
      set_src(2, 10'h1AA);
      step();
      total++;
      if ({pc, redirect, redirect_idx, pending} !== {10'h1AA, 1'b1, 2'd2, 1'b0}) begin
         bad++;
         $display("FAIL tie_live_wins: pc=%h r=%b i=%0d p=%b want pc=1aa r=1 i=2 p=0",
                  pc, redirect, redirect_idx, pending);
      end
      src_valid = 4'b0000;
   endtask

   task automatic test_async_reset();
      stall = 1'b1;
      src_valid = 4'b0100;
      set_src(2, 10'h155);
      step();
      total++;
      if (pending !== 1'b1) begin
         bad++;
         $display("FAIL arst_setup: pending=%b want 1", pending);
      end
      #2;
      rst_n = 1'b0;
      stall = 1'b0;
      src_valid = 4'b0000;
      #1;
      total++;
      if ({pc, redirect, redirect_idx, pending} !== {10'h000, 1'b0, 2'd0, 1'b0}) begin
         bad++;
         $display("FAIL arst_immediate: pc=%h r=%b i=%0d p=%b want pc=000 r=0 i=0 p=0",
                  pc, redirect, redirect_idx, pending);
      end
      step();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         step();
         total++;
         if ({pc, redirect, redirect_idx, pending} !== {10'(k), 1'b0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL arst_recount[%0d]: pc=%h r=%b i=%0d p=%b want pc=%h r=0 i=0 p=0",
                     k, pc, redirect, redirect_idx, pending, 10'(k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_freerun();
      test_wrap();
      test_priority();
      test_stall_capture();
      test_live_vs_pending();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
